// File: rtl/ascon_sequencer.sv
// ascon_sequencer: control FSM sequencing ASCON-128 init, AD, PT and finalization rounds
module ascon_sequencer (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       xor_data_o,
  output logic       xor_key_o,
  output logic       dom_sep_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       done_o
);
  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
  } state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       dom_q, dom_d;
  logic       at_end;
  assign at_end = (cnt_q == 4'd11);
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      dom_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dom_q   <= dom_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dom_d   = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = INIT;
        cnt_d   = 4'd0;
      end
      INIT: begin
        state_d = at_end ? WAIT_AD : INIT;
        cnt_d   = at_end ? 4'd0 : cnt_q + 4'd1;
      end
      WAIT_AD: if (data_valid_i) begin
        state_d = AD;
        cnt_d   = 4'd6;
        last_d  = last_i;
      end
      AD: begin
        state_d = at_end ? (last_q ? WAIT_PT : WAIT_AD) : AD;
        cnt_d   = at_end ? 4'd0 : cnt_q + 4'd1;
        dom_d   = at_end & last_q;
      end
      WAIT_PT: if (data_valid_i) begin
        state_d = last_i ? FINAL : PT;
        cnt_d   = last_i ? 4'd0 : 4'd6;
      end
      PT: begin
        state_d = at_end ? WAIT_PT : PT;
        cnt_d   = at_end ? 4'd0 : cnt_q + 4'd1;
      end
      FINAL: begin
        state_d = at_end ? DONE : FINAL;
        cnt_d   = at_end ? 4'd0 : cnt_q + 4'd1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end
  // Moore outputs: decoded only from state and round counter
  always_comb begin
    enable_o       = (state_q == INIT) | (state_q == AD) | (state_q == PT) | (state_q == FINAL);
    select_o       = enable_o & !((state_q == INIT) & (cnt_q == 4'd0));
    round_o        = enable_o ? cnt_q : 4'd0;
    data_ready_o   = (state_q == WAIT_AD) | (state_q == WAIT_PT);
    xor_data_o     = (((state_q == AD) | (state_q == PT)) & (cnt_q == 4'd6)) |
                     ((state_q == FINAL) & (cnt_q == 4'd0));
    xor_key_o      = ((state_q == INIT) & at_end) |
                     ((state_q == FINAL) & (at_end | (cnt_q == 4'd0)));
    cipher_valid_o = ((state_q == PT) & (cnt_q == 4'd6)) | ((state_q == FINAL) & (cnt_q == 4'd0));
    dom_sep_o      = (state_q == WAIT_PT) & dom_q;
    tag_valid_o    = (state_q == DONE);
    done_o         = (state_q == DONE);
  end
endmodule

// File: tb/tb_ascon_sequencer.sv
// tb_ascon_sequencer: directed self-checking bench for ascon_sequencer
module tb_ascon_sequencer;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, data_valid_i = 1'b0, last_i = 1'b0;
  logic data_ready_o, select_o, enable_o, xor_data_o, xor_key_o;
  logic dom_sep_o, cipher_valid_o, tag_valid_o, done_o;
  logic [3:0] round_o;
  logic [12:0] obs;
  int checks = 0, failures = 0;
  always #5 clk_i = ~clk_i;
  ascon_sequencer dut (
    .clock_i(clk_i), .reset_i(rst_n), .start_i(start_i), .data_valid_i(data_valid_i),
    .last_i(last_i), .data_ready_o(data_ready_o), .select_o(select_o), .enable_o(enable_o),
    .round_o(round_o), .xor_data_o(xor_data_o), .xor_key_o(xor_key_o), .dom_sep_o(dom_sep_o),
    .cipher_valid_o(cipher_valid_o), .tag_valid_o(tag_valid_o), .done_o(done_o)
  );
  assign obs = {data_ready_o, select_o, enable_o, round_o, xor_data_o, xor_key_o,
                dom_sep_o, cipher_valid_o, tag_valid_o, done_o};
  function automatic logic [12:0] ev(input logic rdy, input logic sel, input logic en,
                                     input logic [3:0] rnd, input logic xd, input logic xk,
                                     input logic ds, input logic cv, input logic tv, input logic dn);
    return {rdy, sel, en, rnd, xd, xk, ds, cv, tv, dn};
  endfunction
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    #2 chk("reset_outputs", 13'd0);
    #10 rst_n = 1'b1;
    step;
    chk("idle_after_reset", 13'd0);
    start_i = 1'b1;
    data_valid_i = 1'b1;
    step;
    start_i = 1'b0;
    for (int r = 0; r < 12; r++) begin
      chk($sformatf("init_r%0d", r), ev(0, r != 0, 1, r[3:0], 0, r == 11, 0, 0, 0, 0));
      step;
    end
    chk("wait_ad_1", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step;
    start_i = 1'b1;
    for (int r = 6; r < 12; r++) begin
      chk($sformatf("ad1_r%0d", r), ev(0, 1, 1, r[3:0], r == 6, 0, 0, 0, 0, 0));
      step;
    end
    chk("wait_ad_2", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    start_i = 1'b0;
    last_i = 1'b1;
    step;
    data_valid_i = 1'b0;
    last_i = 1'b0;
    for (int r = 6; r < 12; r++) begin
      chk($sformatf("ad2_r%0d", r), ev(0, 1, 1, r[3:0], r == 6, 0, 0, 0, 0, 0));
      step;
    end
    chk("wait_pt_domsep", ev(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step;
    chk("wait_pt_no_domsep", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    data_valid_i = 1'b1;
    step;
    data_valid_i = 1'b0;
    for (int r = 6; r < 12; r++) begin
      chk($sformatf("pt_r%0d", r), ev(0, 1, 1, r[3:0], r == 6, 0, 0, r == 6, 0, 0));
      step;
    end
    chk("wait_pt_2", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    data_valid_i = 1'b1;
    last_i = 1'b1;
    step;
    data_valid_i = 1'b0;
    last_i = 1'b0;
    for (int r = 0; r < 12; r++) begin
      chk($sformatf("final_r%0d", r), ev(0, 1, 1, r[3:0], r == 0, r == 0 || r == 11, 0, r == 0, 0, 0));
      step;
    end
    chk("done", ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step;
    chk("idle_after_done", 13'd0);
    step;
    chk("idle_stays", 13'd0);
    start_i = 1'b1;
    step;
    start_i = 1'b0;
    chk("init2_r0", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) step;
    chk("init2_r5", ev(0, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_init", 13'd0);
    step;
    chk("held_in_reset", 13'd0);
    #2 rst_n = 1'b1;
    step;
    chk("idle_after_release", 13'd0);
    start_i = 1'b1;
    step;
    start_i = 1'b0;
    chk("restart_r0", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step;
    chk("restart_r1", ev(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascon_sequencer.md
ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 SHALL have port clock_i, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, request a new ASCON-128 encryption; sampled only in IDLE.
REQ-004 SHALL have port data_valid_i, input, 1, the current 64-bit block on the datapath data bus is valid.
REQ-005 SHALL have port last_i, input, 1, the accepted block is the last one of its phase (AD or PT); sampled only on accept.
REQ-006 SHALL have port data_ready_o, output, 1, the sequencer can accept a block.
REQ-007 SHALL have port select_o, output, 1, permutation input select: 0 = load initial state, 1 = feedback register.
REQ-008 SHALL have port enable_o, output, 1, permutation state-register enable.
REQ-009 SHALL have port round_o, output, 4, current round constant index, 0..11.
REQ-010 SHALL have port xor_data_o, output, 1, xor data block into the state.
REQ-011 SHALL have port xor_key_o, output, 1, xor key into the state.
REQ-012 SHALL have port dom_sep_o, output, 1, domain-separation pulse.
REQ-013 SHALL have port cipher_valid_o, output, 1, ciphertext block valid pulse.
REQ-014 SHALL have port tag_valid_o, output, 1, tag valid pulse.
REQ-015 SHALL have port done_o, output, 1, operation complete pulse.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE, plus a 4-bit round counter driving round_o.
REQ-017 SHALL go IDLE->INIT on start_i=1, loading counter=0; start_i SHALL be ignored in every other state.
REQ-018 SHALL run INIT for 12 cycles, round 0..11: select_o=0 on round 0 and 1 on rounds 1..11; xor_key_o=1 on round 11 only; then INIT->WAIT_AD.
REQ-019 SHALL drive data_ready_o=1 only in WAIT_AD and WAIT_PT; a block is accepted on an edge with data_valid_i=1 and data_ready_o=1.
REQ-020 SHALL, on AD accept, enter AD with counter=6 and run rounds 6..11 (6 cycles) with xor_data_o=1 on round 6 only; after round 11 SHALL go to WAIT_PT if the accepted last_i was 1, else back to WAIT_AD.
REQ-021 SHALL pulse dom_sep_o for exactly the first cycle of WAIT_PT.
REQ-022 SHALL, on a PT accept with last_i=0, enter PT: rounds 6..11, xor_data_o=1 and cipher_valid_o=1 on round 6 only; then return to WAIT_PT.
REQ-023 SHALL, on a PT accept with last_i=1, enter FINAL with counter=0: rounds 0..11; on round 0, xor_data_o=1, xor_key_o=1, and cipher_valid_o=1; on round 11, xor_key_o=1; then FINAL->DONE.
REQ-024 SHALL in DONE assert tag_valid_o=1 and done_o=1 for exactly one cycle, then return to IDLE.
REQ-025 SHALL assert enable_o=1 and select_o=1 in AD, PT, FINAL, and INIT rounds 1..11; enable_o=1 in INIT round 0; enable_o=0 in IDLE, WAIT_AD, WAIT_PT, DONE.
REQ-026 SHALL hold round_o at 0 in IDLE, WAIT_AD, WAIT_PT, DONE; all pulse outputs SHALL be 0 outside the cycles specified.
REQ-027 SHALL ignore data_valid_i and last_i outside WAIT_AD and WAIT_PT; the latency from accept to the first permutation round SHALL be 1 cycle.
REQ-028 SHALL make the counter increment by 1 per active round, never wrap past 11, and cause a state exit on reaching 11.

Reset
REQ-029 SHALL on reset_i=0 immediately force IDLE and counter=0 with all outputs 0, including mid-operation; operation SHALL resume only via a new start_i after reset_i returns to 1.

Verification
REQ-030 SHALL cover start_i pulse -> 12 INIT cycles with round_o 0..11, select_o=0 only at round 0, xor_key_o only at round 11, then data_ready_o=1.
REQ-031 SHALL cover 2 AD blocks (last_i on the second) -> each gives 6 cycles of round_o 6..11 with xor_data_o at round 6; dom_sep_o pulses once, then WAIT_PT.
REQ-032 SHALL cover 1 PT block with last_i=0, then 1 with last_i=1 -> cipher_valid_o twice; FINAL rounds 0..11 with xor_key_o at rounds 0 and 11; tag_valid_o and done_o in one cycle, then IDLE.
REQ-033 SHALL cover data_valid_i held high during INIT/AD -> no accept and no extra rounds; start_i during AD -> ignored.
REQ-034 SHALL cover reset_i low at INIT round 5 -> outputs 0 asynchronously, IDLE; a later start_i restarts at round 0.
